// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   WIDTH_DEF : default operand/result width in bits
//   state_t   : control FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_if
// Operand/result handshake bundle for serial_addsub.
//   Input side : in_valid, in_ready, op_sub, a, b
//   Output side: out_valid, out_ready, result, carry_out, overflow
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready; the producer holds its payload stable while valid is high
// and ready is low, and ready never depends combinationally on valid.
//   master : the producer of operands / consumer of results
//   slave  : the arithmetic block
// -----------------------------------------------------------------------------
interface serial_addsub_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );

endinterface

// File: rtl/addsub_bit.sv
// -----------------------------------------------------------------------------
// addsub_bit
// One-bit full adder with optional inversion of b (subtract = a + ~b + 1,
// the +1 comes from the carry preset).
//   a, b   : operand bits
//   cin    : carry in
//   inv_b  : 1 = use ~b (subtract)
//   s      : sum bit
//   cout   : carry out
// -----------------------------------------------------------------------------
module addsub_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic inv_b,
  output logic s,
  output logic cout
);

  logic bx;

  assign bx   = b ^ inv_b;
  assign s    = a ^ bx ^ cin;
  assign cout = (a & bx) | (cin & (a ^ bx));

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's complement adder/subtractor, one bit per clock, LSB first.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : serial_addsub_if.slave (operand and result handshakes)
//   state_o  : current FSM state, for debug/observation
// Optional build macro SERIAL_ADDSUB_SAT_EN: saturate the result to the signed
// max/min on overflow (overflow and carry_out still report raw values).
// Without it the result wraps modulo 2^WIDTH.
// Timing: accept edge, then WIDTH RUN cycles; out_valid rises on the WIDTH-th
// edge after accept. Minimum initiation interval is WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_addsub_if.slave   bus,
  output state_t           state_o
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             op_q,    op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic             bit_s;
  logic             bit_cout;

  // Operands rotate right each RUN cycle, so bit 0 is always the bit being
  // processed; on the last RUN cycle bit 0 holds the original MSB.
  addsub_bit u_bit (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .inv_b (op_q),
    .s     (bit_s),
    .cout  (bit_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone is an accept.
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op_sub;
          cnt_d   = '0;
          carry_d = bus.op_sub;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = {a_q[0], a_q[WIDTH-1:1]};
        b_d     = {b_q[0], b_q[WIDTH-1:1]};
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB here.
          state_d = DONE;
          cout_d  = bit_cout;
          ovf_d   = carry_q ^ bit_cout;
`ifdef SERIAL_ADDSUB_SAT_EN
          if (carry_q ^ bit_cout) begin
            res_d = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
// Directed bench for serial_addsub at WIDTH=8 with hand-computed vectors.
// Honours SERIAL_ADDSUB_SAT_EN for the expected saturated results.
// -----------------------------------------------------------------------------
module tb_serial_addsub;
  import serial_arith_pkg::*;

  localparam int W = 8;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [W-1:0] EXP_7F_PLUS_1  = 8'h7F;
  localparam logic [W-1:0] EXP_80_MINUS_1 = 8'h80;
`else
  localparam logic [W-1:0] EXP_7F_PLUS_1  = 8'h80;
  localparam logic [W-1:0] EXP_80_MINUS_1 = 8'h7F;
`endif

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(1'b1));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(1'b0));
    check({tag, ".result"},    64'(bus.result),    64'(8'h00));
    check({tag, ".carry_out"}, 64'(bus.carry_out), 64'(1'b0));
    check({tag, ".overflow"},  64'(bus.overflow),  64'(1'b0));
    check({tag, ".state"},     64'(dbg_state),     64'(IDLE));
  endtask

  // driver: one full operation, optionally stalling 'hold' cycles in DONE
  // with an in_valid pulse carrying fresh operands during the stall.
  task automatic do_op(input string tag, input logic sub,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ec, input logic ev,
                       input int hold);
    bus.in_valid = 1'b1;
    bus.op_sub   = sub;
    bus.a        = a;
    bus.b        = b;
    check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'(1'b1));
    tick();                                   // accept edge
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);              // must not reach the result
    bus.b        = W'($urandom);
    bus.op_sub   = ~sub;
    check({tag, ".state_run"},    64'(dbg_state),    64'(RUN));
    check({tag, ".in_ready_run"}, 64'(bus.in_ready), 64'(1'b0));
    repeat (W - 1) tick();
    check({tag, ".out_valid_early"}, 64'(bus.out_valid), 64'(1'b0));
    tick();                                   // W-th edge after accept
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(1'b1));
    check({tag, ".result"},    64'(bus.result),    64'(er));
    check({tag, ".carry_out"}, 64'(bus.carry_out), 64'(ec));
    check({tag, ".overflow"},  64'(bus.overflow),  64'(ev));
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.op_sub   = 1'b1;
        bus.a        = 8'hAA;
        bus.b        = 8'h55;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      check({tag, ".hold_valid"},  64'(bus.out_valid), 64'(1'b1));
      check({tag, ".hold_ready"},  64'(bus.in_ready),  64'(1'b0));
      check({tag, ".hold_result"}, 64'(bus.result),    64'(er));
      check({tag, ".hold_carry"},  64'(bus.carry_out), 64'(ec));
      check({tag, ".hold_ovf"},    64'(bus.overflow),  64'(ev));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();                                   // output handshake edge
    bus.out_ready = 1'b0;
    check({tag, ".post_valid"}, 64'(bus.out_valid), 64'(1'b0));
    check({tag, ".post_ready"}, 64'(bus.in_ready),  64'(1'b1));
    check({tag, ".post_state"}, 64'(dbg_state),     64'(IDLE));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #1;
    check_idle_reset("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_reset("after_reset");

    // arithmetic vectors
    do_op("add_05_03", 1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 0);
    do_op("sub_03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 0);
    do_op("sub_05_03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 0);
    do_op("add_7f_01", 1'b0, 8'h7F, 8'h01, EXP_7F_PLUS_1,  1'b0, 1'b1, 0);
    do_op("sub_80_01", 1'b1, 8'h80, 8'h01, EXP_80_MINUS_1, 1'b1, 1'b1, 0);
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);

    // back-pressure in DONE with an ignored in_valid pulse
    do_op("stall_12_34", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 5);
    tick();
    check("stall.no_restart_valid", 64'(bus.out_valid), 64'(1'b0));
    check("stall.no_restart_state", 64'(dbg_state),     64'(IDLE));

    // reset during the 4th RUN cycle
    bus.in_valid = 1'b1;
    bus.op_sub   = 1'b0;
    bus.a        = 8'h0F;
    bus.b        = 8'h0F;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("abort.state_run", 64'(dbg_state), 64'(RUN));
    rst_n = 1'b0;
    #1;
    check_idle_reset("abort");
    tick();
    check_idle_reset("abort_held");
    rst_n = 1'b1;
    do_op("post_abort_add", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
